// File: rtl/seq_divider.sv
// Multi-cycle non-restoring integer divider: one quotient bit per clock,
// signed or unsigned, with explicit divide-by-zero and MIN/-1 overflow reporting.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output logic [2:0]       state_o
);

    // Handshake: start is sampled only in IDLE (operands captured on that edge);
    // done pulses for one cycle and the results stay valid until the next done.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d, m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic             dbz_q, dbz_d, ovf_q, ovf_d;

    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   a_sh, a_step, a_fix;
    logic             is_ovf;

    assign dvd_mag = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
    assign dvs_mag = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
    assign is_ovf  = sgn_q && (dvd_q == MIN_VAL) && (dvs_q == {WIDTH{1'b1}});

    // The sign of A before the shift selects subtract or add-back of the divisor.
    assign a_sh   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign a_step = a_q[WIDTH] ? (a_sh + {1'b0, m_q}) : (a_sh - {1'b0, m_q});
    assign a_fix  = a_q[WIDTH] ? (a_q + {1'b0, m_q}) : a_q;

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    sgn_d   = is_signed;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                if (dvs_q == '0) begin
                    quot_d  = '1;
                    rem_d   = dvd_q;
                    dbz_d   = 1'b1;
                    ovf_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    m_d     = dvs_mag;
                    q_d     = dvd_mag;
                    a_d     = '0;
                    cnt_d   = '0;
                    q_neg_d = sgn_q && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    r_neg_d = sgn_q && dvd_q[WIDTH-1];
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                a_d = a_step;
                q_d = {q_q[WIDTH-2:0], ~a_step[WIDTH]};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIX: begin
                dbz_d = 1'b0;
                ovf_d = is_ovf;
                if (is_ovf) begin
                    quot_d = MIN_VAL;
                    rem_d  = '0;
                end else begin
                    quot_d = q_neg_q ? -q_q : q_q;
                    rem_d  = r_neg_q ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: one 32-bit lane for directed cases and four 8-bit
// lanes for a parallel random sweep, all checked against an arithmetic model.
module tb_seq_divider;

    localparam int NL = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int total = 0;
    int bad = 0;

    logic        start [NL];
    logic        sgn   [NL];
    logic [31:0] dvd   [NL];
    logic [31:0] dvs   [NL];
    logic        busy  [NL];
    logic        done  [NL];
    logic        dbz   [NL];
    logic        ovf   [NL];
    logic [31:0] quot  [NL];
    logic [31:0] rem   [NL];
    logic [2:0]  st    [NL];

    seq_divider #(.WIDTH(32), .CNT_W(6)) u_div32 (
        .clk(clk), .clr_n(clr_n), .start(start[0]), .is_signed(sgn[0]),
        .dividend(dvd[0]), .divisor(dvs[0]), .busy(busy[0]), .done(done[0]),
        .quotient(quot[0]), .remainder(rem[0]), .div_by_zero(dbz[0]),
        .overflow(ovf[0]), .state_o(st[0])
    );

    for (genvar g = 1; g < NL; g++) begin : g_w8
        logic [7:0] q8, r8;
        logic [2:0] s8;
        seq_divider #(.WIDTH(8), .CNT_W(4)) u_div8 (
            .clk(clk), .clr_n(clr_n), .start(start[g]), .is_signed(sgn[g]),
            .dividend(dvd[g][7:0]), .divisor(dvs[g][7:0]), .busy(busy[g]), .done(done[g]),
            .quotient(q8), .remainder(r8), .div_by_zero(dbz[g]),
            .overflow(ovf[g]), .state_o(s8)
        );
        assign quot[g] = {24'd0, q8};
        assign rem[g]  = {24'd0, r8};
        assign st[g]   = s8;
    end

    // ---------------- reference model ----------------
    function automatic int lane_w(input int l);
        return (l == 0) ? 32 : 8;
    endfunction

    function automatic logic [31:0] wmask(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic void model(input int w, input bit s, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] q,
                                  output logic [31:0] r, output bit dz, output bit ov);
        longint sa, sb, mask;
        mask = (longint'(1) << w) - 1;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 32'd0) begin
            q  = wmask(w);
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = a[w-1] ? (longint'(a) - (longint'(1) << w)) : longint'(a);
            sb = b[w-1] ? (longint'(b) - (longint'(1) << w)) : longint'(b);
            q  = 32'((sa / sb) & mask);
            r  = 32'((sa % sb) & mask);
            ov = (sb == -1) && (sa == -(longint'(1) << (w - 1)));
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // ---------------- scoreboard / compare process ----------------
    logic [65:0] exp_q [NL][$];
    int          exp_t [NL][$];
    logic [65:0] hold  [NL];

    always @(negedge clk) begin
        logic [65:0] act;
        int t;
        for (int l = 0; l < NL; l++) begin
            if (!clr_n) begin
                exp_q[l].delete();
                exp_t[l].delete();
                hold[l] = '0;
            end else begin
                act = {quot[l], rem[l], dbz[l], ovf[l]};
                if (done[l]) begin
                    total++;
                    if (exp_q[l].size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_done lane=%0d edge=%0d", l, edge_cnt);
                    end else begin
                        hold[l] = exp_q[l].pop_front();
                        t = exp_t[l].pop_front();
                        if (act !== hold[l]) begin
                            bad++;
                            $display("FAIL result lane=%0d got=%h want=%h", l, act, hold[l]);
                        end
                        total++;
                        if (edge_cnt != t) begin
                            bad++;
                            $display("FAIL latency lane=%0d got_edge=%0d want_edge=%0d", l, edge_cnt, t);
                        end
                        total++;
                        if (busy[l] !== 1'b1) begin
                            bad++;
                            $display("FAIL busy_at_done lane=%0d got=%b want=1", l, busy[l]);
                        end
                    end
                end else if (!busy[l]) begin
                    total++;
                    if (act !== hold[l]) begin
                        bad++;
                        $display("FAIL hold lane=%0d got=%h want=%h", l, act, hold[l]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    task automatic issue(input int l, input bit s, input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] q, r, a, b;
        bit dz, ov;
        int w;
        w = lane_w(l);
        a = a_in & wmask(w);
        b = b_in & wmask(w);
        model(w, s, a, b, q, r, dz, ov);
        @(negedge clk);
        start[l] = 1'b1;
        sgn[l]   = s;
        dvd[l]   = a;
        dvs[l]   = b;
        @(posedge clk);
        #1;
        exp_q[l].push_back({q, r, dz, ov});
        exp_t[l].push_back(edge_cnt + ((b == 32'd0) ? 2 : (w + 3)) - 1);
        start[l] = 1'b0;
        sgn[l]   = ~s;
        dvd[l]   = $urandom & wmask(w);
        dvs[l]   = $urandom & wmask(w);
    endtask

    task automatic wait_done(input int l, output int busy_cycles);
        bit got;
        got = 1'b0;
        busy_cycles = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (busy[l]) busy_cycles++;
            if (done[l]) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL done_timeout lane=%0d got=0 want=1", l);
        end
    endtask

    task automatic run(input bit s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] wq, input logic [31:0] wr, input string name);
        int bc;
        issue(0, s, a, b);
        wait_done(0, bc);
        chk({name, "_q"}, quot[0], wq);
        chk({name, "_r"}, rem[0], wr);
    endtask

    task automatic sweep(input int l);
        logic [31:0] a, b;
        logic [7:0] spec [5];
        int bc;
        spec = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        for (int i = 0; i < 2500; i++) begin
            a = ($urandom_range(0, 7) == 0) ? {24'd0, spec[$urandom_range(0, 4)]} : $urandom_range(0, 255);
            b = ($urandom_range(0, 7) == 0) ? {24'd0, spec[$urandom_range(0, 4)]} : $urandom_range(0, 255);
            issue(l, 1'($urandom_range(0, 1)), a, b);
            wait_done(l, bc);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] mq, mr;
        bit mdz, mov;
        int bc, done_seen;

        for (int l = 0; l < NL; l++) begin
            start[l] = 1'b0;
            sgn[l]   = 1'b0;
            dvd[l]   = '0;
            dvs[l]   = '0;
        end

        // Pin the model with hand-computed values.
        model(32, 1'b1, 32'hFFFF_FF9C, 32'd7, mq, mr, mdz, mov);
        chk("model_neg100_7_q", mq, 32'hFFFF_FFF2);
        chk("model_neg100_7_r", mr, 32'hFFFF_FFFE);
        model(8, 1'b1, 32'h80, 32'hFF, mq, mr, mdz, mov);
        chk("model_ovf8_q", mq, 32'h80);
        chk("model_ovf8_flag", 32'(mov), 32'd1);
        model(8, 1'b0, 32'd200, 32'd0, mq, mr, mdz, mov);
        chk("model_dbz8_q", mq, 32'hFF);
        chk("model_dbz8_r", mr, 32'd200);

        repeat (2) @(negedge clk);
        chk("reset_state", 32'(st[0]), 32'd0);
        chk("reset_busy", 32'(busy[0]), 32'd0);
        chk("reset_done", 32'(done[0]), 32'd0);
        chk("reset_quot", quot[0], 32'd0);
        chk("reset_rem", rem[0], 32'd0);
        chk("reset_flags", {30'd0, dbz[0], ovf[0]}, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;

        // Unsigned 100/7 with busy window
        issue(0, 1'b0, 32'd100, 32'd7);
        wait_done(0, bc);
        chk("u100_7_q", quot[0], 32'd14);
        chk("u100_7_r", rem[0], 32'd2);
        chk("u100_7_flags", {30'd0, dbz[0], ovf[0]}, 32'd0);
        chk("u100_7_busy_cycles", 32'(bc), 32'd35);
        @(negedge clk);
        chk("u100_7_idle_after", 32'(busy[0]), 32'd0);

        // Signed quadrants
        run(1'b1, 32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFF2, 32'hFFFF_FFFE, "sn100_7");
        run(1'b1, 32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2, 32'd2,         "s100_n7");
        run(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'd14,        32'hFFFF_FFFE, "sn100_n7");

        // Divide by zero, then a valid divide clears the flag
        issue(0, 1'b0, 32'h1234, 32'd0);
        wait_done(0, bc);
        chk("dbz_q", quot[0], 32'hFFFF_FFFF);
        chk("dbz_r", rem[0], 32'h1234);
        chk("dbz_flag", 32'(dbz[0]), 32'd1);
        chk("dbz_busy_cycles", 32'(bc), 32'd2);
        run(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, "after_dbz");
        chk("dbz_cleared", 32'(dbz[0]), 32'd0);

        // Overflow signed, and the same bits unsigned
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "sovf");
        chk("sovf_flag", 32'(ovf[0]), 32'd1);
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "uovf");
        chk("uovf_flag", 32'(ovf[0]), 32'd0);

        // start pulsed during ITER must be ignored
        issue(0, 1'b0, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        start[0] = 1'b1;
        dvd[0]   = 32'd7;
        dvs[0]   = 32'd7;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, bc);
        chk("ignored_start_q", quot[0], 32'd333);
        chk("ignored_start_r", rem[0], 32'd1);

        // Back-to-back: second start in the cycle right after done
        run(1'b1, 32'hFFFF_FC18, 32'd33, 32'hFFFF_FFE2, 32'hFFFF_FFF6, "b2b_first");
        run(1'b0, 32'd77, 32'd10, 32'd7, 32'd7, "b2b_second");

        // Abort mid-iteration
        issue(0, 1'b0, 32'd500, 32'd9);
        repeat (12) @(negedge clk);
        clr_n = 1'b0;
        #2;
        chk("abort_state", 32'(st[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_done", 32'(done[0]), 32'd0);
        chk("abort_quot", quot[0], 32'd0);
        chk("abort_rem", rem[0], 32'd0);
        chk("abort_flags", {30'd0, dbz[0], ovf[0]}, 32'd0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done[0]) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        run(1'b0, 32'd500, 32'd9, 32'd55, 32'd5, "after_abort");

        // 8-bit random sweep on four lanes in parallel
        fork
            sweep(1);
            sweep(2);
            sweep(3);
            sweep(4);
        join

        repeat (5) @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            chk("queue_drained", 32'(exp_q[l].size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
